// File: rtl/serial_tx.sv
`timescale 1ns/1ps
// serial_tx -- asynchronous-style serial frame transmitter.
//
// Sends one frame per accepted request: a start bit (0), DATA_BITS payload
// bits LSB first, an optional parity bit, then STOP_BITS stop bits (1).
// Bit timing comes from TICKIN, a divided bit-rate clock that is
// asynchronous to CLK. It is synchronised and edge-detected into a one-CLK
// strobe (te). Each te advances the frame by one bit period.
//
// Handshake (START/READY): a request is taken on a rising CLK edge where
// READY and START are both high. The payload is captured on that edge.
// READY drops on the following cycle. It returns one cycle after the frame
// completes or is aborted. A START seen while READY is low is dropped, not
// remembered.
//
// Ports
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   TICKIN     bit-rate clock; one rising edge per bit period
//   DATA       payload, captured on accept
//   START      transmit request (level, sampled every CLK)
//   ABORT      synchronous cancel of the frame in progress
//   TX         serial line, idle high
//   READY      high when a START will be accepted
//   DONE       one-CLK pulse when a frame completes normally
//   STATE_DBG  current FSM state:
//                0 IDLE, 1 ARMED, 2 STARTB, 3 DATAB, 4 PARB, 5 STOPB
module serial_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 TICKIN,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 START,
  input  logic                 ABORT,
  output logic                 TX,
  output logic                 READY,
  output logic                 DONE,
  output logic [2:0]           STATE_DBG
);

  localparam int CNT_W = $clog2(DATA_BITS + 2);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    STARTB = 3'd2,
    DATAB  = 3'd3,
    PARB   = 3'd4,
    STOPB  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------
  // TICKIN synchroniser and rising-edge detector.
  // sync_fill keeps te low until tick_d holds a real post-reset sample.
  // This means a TICKIN that is already high when reset releases is not
  // mistaken for a fresh edge.
  // ---------------------------------------------------------------------
  logic       tick_s1, tick_s2, tick_d;
  logic [2:0] sync_fill;
  logic       te;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_d    <= 1'b0;
      sync_fill <= 3'b000;
    end else begin
      tick_s1   <= TICKIN;
      tick_s2   <= tick_s1;
      tick_d    <= tick_s2;
      sync_fill <= {sync_fill[1:0], 1'b1};
    end
  end

  assign te = tick_s2 & ~tick_d & sync_fill[2];

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_step;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   accept;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    par_d    = par_q;
    cnt_step = cnt_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    accept   = 1'b0;

    // ABORT wins over a te arriving on the same edge.
    if (state_q != IDLE && ABORT) begin
      state_d = IDLE;
      tx_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (ready_q && START) begin
            accept  = 1'b1;
            shift_d = DATA;
            // Parity is taken from the payload as captured, so later
            // DATA changes cannot reach the frame.
            par_d   = (^DATA) ^ ODD;
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (te) begin
            state_d = STARTB;
            tx_d    = 1'b0;
          end
        end
        STARTB: begin
          if (te) begin
            state_d = DATAB;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        DATAB: begin
          if (te) begin
            if (cnt_q == LAST_DATA) begin
              if (PARITY_EN != 0) begin
                state_d = PARB;
                tx_d    = par_q;
              end else begin
                state_d = STOPB;
                tx_d    = 1'b1;
              end
            end else begin
              cnt_step = cnt_q + CNT_W'(1);
              tx_d     = shift_q[0];
              shift_d  = shift_q >> 1;
            end
          end
        end
        PARB: begin
          if (te) begin
            state_d = STOPB;
            tx_d    = 1'b1;
          end
        end
        STOPB: begin
          if (te) begin
            if (cnt_q == LAST_STOP) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_step = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    // The bit counter restarts on every state change. It only advances
    // while below its terminal count, so it never wraps.
    cnt_d = (state_d != state_q) ? '0 : cnt_step;

    // READY is low from the cycle after accept until one cycle after
    // the FSM is back in IDLE. This covers both DONE and ABORT.
    ready_d = (state_q == IDLE) && !accept;
  end

  assign TX        = tx_q;
  assign READY     = ready_q;
  assign DONE      = done_q;
  assign STATE_DBG = state_q;

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The parameter DATA_BITS SHALL default to 8 and SHALL set the payload bits per frame, legal range 5..9.
REQ-002 The parameter PARITY_EN SHALL default to 0; when it is 1, one parity bit SHALL follow the data bits.
REQ-003 The parameter PARITY_ODD SHALL default to 0; 0 selects even parity and 1 selects odd parity, and it SHALL be ignored when PARITY_EN=0.
REQ-004 The parameter STOP_BITS SHALL default to 1, with legal values 1 and 2.
REQ-005 Port CLK SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-006 Port RST_N SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-007 Port TICKIN SHALL be an input, 1 bit wide: the divided bit-rate clock from the upstream clock divider, asynchronous to CLK; each rising edge marks one bit period.
REQ-008 Port DATA SHALL be an input, DATA_BITS wide: the payload, sampled on accept.
REQ-009 Port START SHALL be an input, 1 bit wide: a transmit request, level-sampled each CLK.
REQ-010 Port ABORT SHALL be an input, 1 bit wide: synchronous cancel of the frame in progress.
REQ-011 Port TX SHALL be an output, 1 bit wide: the serial line, idle high.
REQ-012 Port READY SHALL be an output, 1 bit wide: high when a START will be accepted.
REQ-013 Port DONE SHALL be an output, 1 bit wide: a one-CLK pulse on normal frame completion.

Function
REQ-014 TICKIN SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, producing strobe TE that is high for exactly one CLK per TICKIN rising edge; TE latency from the TICKIN edge SHALL be 2-3 CLK.
REQ-015 The FSM states SHALL be IDLE, ARMED, STARTB, DATAB, PARB and STOPB, all registered.
REQ-016 In IDLE with READY=1, START=1 SHALL be accepted: DATA is latched into a shift register, the state goes to ARMED, and READY goes to 0 on the next CLK.
REQ-017 In ARMED, TE SHALL move the FSM to STARTB with TX=0 on the same clock edge.
REQ-018 In STARTB, TE SHALL move the FSM to DATAB and drive TX=bit0 (LSB first).
REQ-019 In DATAB, each TE SHALL shift out the next bit; on the TE after bit DATA_BITS-1, the FSM SHALL go to PARB if PARITY_EN=1, otherwise to STOPB with TX=1.
REQ-020 In PARB, TX SHALL equal the XOR of the latched data bits, inverted when PARITY_ODD=1; the next TE SHALL move the FSM to STOPB with TX=1.
REQ-021 STOPB SHALL last STOP_BITS TE periods, counted by the bit counter; on the final TE the FSM SHALL return to IDLE, pulse DONE for that one CLK, and set READY=1 on the following CLK.
REQ-022 Frame timing SHALL be: for TE edges numbered k=1.. after accept, the edge at k=2+DATA_BITS+PARITY_EN+STOP_BITS SHALL produce DONE.
REQ-023 The bit counter SHALL be ceil(log2(DATA_BITS+2)) bits wide, SHALL clear on every state change, and SHALL never wrap.
REQ-024 START while READY=0 SHALL be ignored, including in the DONE cycle, and SHALL NOT be queued.
REQ-025 DATA changes after accept SHALL NOT affect the frame in flight.
REQ-026 ABORT=1 in any non-IDLE state SHALL force IDLE, TX=1 and DONE=0 on the next CLK, with READY=1 one CLK later.
REQ-027 ABORT SHALL have priority over a TE in the same cycle.
REQ-028 ABORT SHALL be ignored in IDLE.
REQ-029 If START and ABORT are both high in IDLE, the START SHALL be accepted.
REQ-030 A TICKIN that is stopped SHALL hold the FSM in its current state indefinitely, with no timeout.

Reset
REQ-031 While RST_N=0, the block SHALL hold TX=1, READY=1, DONE=0, the FSM in IDLE, and the shift register, bit counter and synchronizer flops all at 0, independent of CLK.
REQ-032 Assertion of RST_N mid-frame SHALL abandon the frame immediately, with no DONE.
REQ-033 After RST_N deassertion, the first TE SHALL be generated only by a TICKIN rising edge seen after reset.

Verification
REQ-034 With defaults, DATA=8'hA5 and START pulsed: TX SHALL show 0,1,0,1,0,0,1,0,1 then 1, each level lasting one TICKIN period, and DONE SHALL pulse at TE #11.
REQ-035 With PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2 and DATA=8'h03: the parity bit SHALL be 1, there SHALL be two stop periods, and DONE SHALL pulse at TE #13.
REQ-036 With START held high continuously: frames SHALL be back-to-back, with READY low exactly from accept+1 to DONE+1, and each new frame's start bit SHALL begin at the first TE after re-accept.
REQ-037 With ABORT=1 coincident with a TE during DATAB bit 3: TX SHALL be 1 the next CLK, no DONE SHALL occur, and READY SHALL be 1 two CLK after ABORT.
REQ-038 With RST_N pulsed low for 1 ns mid-STARTB, asynchronous to CLK: TX=1 and READY=1 SHALL appear immediately, and a subsequent DATA=8'h5A frame SHALL be transmitted correctly.
REQ-039 With TICKIN held constant for 1000 CLK after accept: TX SHALL stay 1 and the FSM SHALL stay in ARMED throughout.
